// File: rtl/packet_length_checker_pkg.sv
// ----------------------------------------------------------------------------
// packet_length_checker_pkg
// Shared widths and helpers for the packet length checker.
//   ACC_W      : width of the per-packet byte accumulator (saturating)
//   CNT_W      : width of each statistics counter (saturating)
//   MAX_KEEP_W : widest TKEEP the popcount helper accepts (DW up to 1024)
//   popcount() : number of set bits in a (zero-extended) TKEEP vector
// ----------------------------------------------------------------------------
package packet_length_checker_pkg;

   localparam int ACC_W      = 16;
   localparam int CNT_W      = 32;
   localparam int MAX_KEEP_W = 128;

   function automatic logic [ACC_W-1:0] popcount(input logic [MAX_KEEP_W-1:0] keep);
      logic [ACC_W-1:0] n;
      n = '0;
      for (int i = 0; i < MAX_KEEP_W; i++) begin
         n = n + {{(ACC_W-1){1'b0}}, keep[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/packet_length_checker_skid.sv
// ----------------------------------------------------------------------------
// axis_skid_buffer
// Two-entry register FIFO between an upstream and a downstream valid/ready
// interface. A beat accepted on one edge is presented on the output right
// after that edge; with the output always ready it sustains one beat/cycle.
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   in_data/valid/ready    : upstream side (W-bit payload)
//   out_data/valid/ready   : downstream side; out_data reads 0 when empty
// ----------------------------------------------------------------------------
module axis_skid_buffer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         run_q;
   logic         in_fire, out_fire;

   // run_q holds ready low through reset and raises it on the first edge after.
   assign in_ready  = run_q && (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   // Gate the payload so TUSER/TLAST read 0 whenever nothing is held.
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      wr_ptr_d = wr_ptr_q ^ in_fire;
      rd_ptr_d = rd_ptr_q ^ out_fire;
      count_d  = count_q;
      case ({in_fire, out_fire})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         run_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         run_q    <= 1'b1;
      end
   end

   // Storage needs no reset: it is only visible through out_valid.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

endmodule

// File: rtl/packet_length_checker.sv
// ----------------------------------------------------------------------------
// packet_length_checker
// AXI-Stream pass-through that measures each packet's byte length and marks
// runts, giants and upstream-errored packets on the TLAST beat's TUSER.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   AXIS_IN_*                   : input stream (TUSER = upstream error)
//   AXIS_OUT_*                  : output stream (TUSER = bad-packet mark)
//   clear_counters              : synchronous clear of the statistics
//   good/runt/giant/upstream_err_count : saturating packet counters
//   bad_packet_strb             : one-cycle pulse per bad packet, raised on
//                                 the edge that accepts its last beat
// ----------------------------------------------------------------------------
module packet_length_checker
   import packet_length_checker_pkg::*;
#(
   parameter int DW        = 512,
   parameter int MIN_BYTES = 64,
   parameter int MAX_BYTES = 9600
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DW-1:0]    AXIS_IN_TDATA,
   input  logic [DW/8-1:0]  AXIS_IN_TKEEP,
   input  logic             AXIS_IN_TUSER,
   input  logic             AXIS_IN_TLAST,
   input  logic             AXIS_IN_TVALID,
   output logic             AXIS_IN_TREADY,
   output logic [DW-1:0]    AXIS_OUT_TDATA,
   output logic [DW/8-1:0]  AXIS_OUT_TKEEP,
   output logic             AXIS_OUT_TUSER,
   output logic             AXIS_OUT_TLAST,
   output logic             AXIS_OUT_TVALID,
   input  logic             AXIS_OUT_TREADY,
   input  logic             clear_counters,
   output logic [CNT_W-1:0] good_count,
   output logic [CNT_W-1:0] runt_count,
   output logic [CNT_W-1:0] giant_count,
   output logic [CNT_W-1:0] upstream_err_count,
   output logic             bad_packet_strb
);

   localparam int KW = DW / 8;
   localparam int PW = DW + KW + 2;
   localparam logic [ACC_W-1:0] MIN_LEN = ACC_W'(MIN_BYTES);
   localparam logic [ACC_W-1:0] MAX_LEN = ACC_W'(MAX_BYTES);

   logic             in_ready;
   logic             in_fire, last_fire;
   logic [ACC_W-1:0] beat_bytes;
   logic [ACC_W:0]   sum_full;
   logic [ACC_W-1:0] pkt_len;
   logic             pkt_err, is_runt, is_giant, is_bad;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             err_q, err_d;
   logic             strb_q, strb_d;
   logic [3:0]       inc;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [PW-1:0]    skid_in, skid_out;

   assign AXIS_IN_TREADY = in_ready;
   assign in_fire        = AXIS_IN_TVALID && in_ready;
   assign last_fire      = in_fire && AXIS_IN_TLAST;

   // Length including the current beat, saturating at the accumulator width.
   // Because MAX_BYTES is below the saturation value, a saturated length is
   // still classed as a giant.
   assign beat_bytes = popcount(MAX_KEEP_W'(AXIS_IN_TKEEP));
   assign sum_full   = {1'b0, acc_q} + {1'b0, beat_bytes};
   assign pkt_len    = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
   assign pkt_err    = err_q || AXIS_IN_TUSER;
   assign is_runt    = (pkt_len < MIN_LEN);
   assign is_giant   = (pkt_len > MAX_LEN);
   assign is_bad     = is_runt || is_giant || pkt_err;

   // Counter order: good, runt, giant, upstream error.
   assign inc[0] = last_fire && !is_bad;
   assign inc[1] = last_fire && is_runt;
   assign inc[2] = last_fire && is_giant;
   assign inc[3] = last_fire && pkt_err;

   always_comb begin
      acc_d  = acc_q;
      err_d  = err_q;
      strb_d = last_fire && is_bad;
      if (in_fire) begin
         if (AXIS_IN_TLAST) begin
            acc_d = '0;
            err_d = 1'b0;
         end else begin
            acc_d = pkt_len;
            err_d = pkt_err;
         end
      end
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clear_counters) begin
            cnt_d[i] = '0;
         end else if (inc[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q  <= '0;
         err_q  <= 1'b0;
         strb_q <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         acc_q  <= acc_d;
         err_q  <= err_d;
         strb_q <= strb_d;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign good_count         = cnt_q[0];
   assign runt_count         = cnt_q[1];
   assign giant_count        = cnt_q[2];
   assign upstream_err_count = cnt_q[3];
   assign bad_packet_strb    = strb_q;

   // The bad mark rides along with the beat; it is only set on the last beat.
   assign skid_in = {AXIS_IN_TLAST && is_bad, AXIS_IN_TLAST, AXIS_IN_TKEEP, AXIS_IN_TDATA};

   axis_skid_buffer #(
      .W (PW)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_data   (skid_in),
      .in_valid  (AXIS_IN_TVALID),
      .in_ready  (in_ready),
      .out_data  (skid_out),
      .out_valid (AXIS_OUT_TVALID),
      .out_ready (AXIS_OUT_TREADY)
   );

   assign {AXIS_OUT_TUSER, AXIS_OUT_TLAST, AXIS_OUT_TKEEP, AXIS_OUT_TDATA} = skid_out;

endmodule

// File: tb/tb_packet_length_checker.sv
// ----------------------------------------------------------------------------
// tb_packet_length_checker
// Directed stimulus against packet_length_checker (DW=512, 64..9600 bytes).
// A reference model tracks accepted beats in a queue and packet statistics
// with plain integer arithmetic; a negedge process compares every cycle.
// ----------------------------------------------------------------------------
module tb_packet_length_checker;

   localparam int DW    = 512;
   localparam int KW    = DW / 8;
   localparam int MIN_B = 64;
   localparam int MAX_B = 9600;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] AXIS_IN_TDATA;
   logic [KW-1:0] AXIS_IN_TKEEP;
   logic          AXIS_IN_TUSER, AXIS_IN_TLAST, AXIS_IN_TVALID, AXIS_IN_TREADY;
   logic [DW-1:0] AXIS_OUT_TDATA;
   logic [KW-1:0] AXIS_OUT_TKEEP;
   logic          AXIS_OUT_TUSER, AXIS_OUT_TLAST, AXIS_OUT_TVALID;
   logic          AXIS_OUT_TREADY = 1'b1;
   logic          clear_counters;
   logic [31:0]   good_count, runt_count, giant_count, upstream_err_count;
   logic          bad_packet_strb;

   packet_length_checker #(
      .DW (DW), .MIN_BYTES (MIN_B), .MAX_BYTES (MAX_B)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .AXIS_IN_TDATA      (AXIS_IN_TDATA),
      .AXIS_IN_TKEEP      (AXIS_IN_TKEEP),
      .AXIS_IN_TUSER      (AXIS_IN_TUSER),
      .AXIS_IN_TLAST      (AXIS_IN_TLAST),
      .AXIS_IN_TVALID     (AXIS_IN_TVALID),
      .AXIS_IN_TREADY     (AXIS_IN_TREADY),
      .AXIS_OUT_TDATA     (AXIS_OUT_TDATA),
      .AXIS_OUT_TKEEP     (AXIS_OUT_TKEEP),
      .AXIS_OUT_TUSER     (AXIS_OUT_TUSER),
      .AXIS_OUT_TLAST     (AXIS_OUT_TLAST),
      .AXIS_OUT_TVALID    (AXIS_OUT_TVALID),
      .AXIS_OUT_TREADY    (AXIS_OUT_TREADY),
      .clear_counters     (clear_counters),
      .good_count         (good_count),
      .runt_count         (runt_count),
      .giant_count        (giant_count),
      .upstream_err_count (upstream_err_count),
      .bad_packet_strb    (bad_packet_strb)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
      logic          u;
   } beat_t;

   beat_t exp_q[$];
   int    m_cnt[4];     // good, runt, giant, upstream error
   int    m_len;
   bit    m_err;
   bit    m_ready_en;
   bit    m_strb;
   bit    rand_ready;

   // statistics for the hand-computed checks
   int    strb_hits, user_hits, user_pos, out_pkts, out_beat, out_bytes;
   bit    last_user;
   logic [7:0] user_hist;

   task automatic clear_stats();
      strb_hits = 0; user_hits = 0; user_pos = 0; out_pkts = 0; user_hist = '0;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         chk("rst_in_ready",  64'(AXIS_IN_TREADY), 64'(0));
         chk("rst_out_valid", 64'(AXIS_OUT_TVALID), 64'(0));
         chk("rst_out_user",  64'(AXIS_OUT_TUSER), 64'(0));
         chk("rst_out_last",  64'(AXIS_OUT_TLAST), 64'(0));
         chk("rst_strb",      64'(bad_packet_strb), 64'(0));
         chk("rst_counters",  {good_count | runt_count, giant_count | upstream_err_count}, 64'(0));
         exp_q.delete();
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
         m_len = 0; m_err = 0; m_ready_en = 0; m_strb = 0; out_beat = 0; out_bytes = 0;
      end else begin
         chk("in_ready",  64'(AXIS_IN_TREADY), 64'(m_ready_en && exp_q.size() < 2));
         chk("out_valid", 64'(AXIS_OUT_TVALID), 64'(exp_q.size() != 0));
         if (AXIS_OUT_TVALID && exp_q.size() != 0) begin
            chk_data("out_data", AXIS_OUT_TDATA, exp_q[0].d);
            chk("out_keep", 64'(AXIS_OUT_TKEEP), 64'(exp_q[0].k));
            chk("out_last", 64'(AXIS_OUT_TLAST), 64'(exp_q[0].l));
            chk("out_user", 64'(AXIS_OUT_TUSER), 64'(exp_q[0].u));
         end
         chk("strb",      64'(bad_packet_strb), 64'(m_strb));
         chk("good_cnt",  64'(good_count), 64'(m_cnt[0]));
         chk("runt_cnt",  64'(runt_count), 64'(m_cnt[1]));
         chk("giant_cnt", 64'(giant_count), 64'(m_cnt[2]));
         chk("uerr_cnt",  64'(upstream_err_count), 64'(m_cnt[3]));
         if (bad_packet_strb) strb_hits++;

         // predict the coming edge
         m_strb = 0;
         if (AXIS_OUT_TVALID && AXIS_OUT_TREADY && exp_q.size() != 0) begin
            beat_t b;
            b = exp_q.pop_front();
            out_beat++;
            out_bytes += $countones(b.k);
            if (AXIS_OUT_TUSER) begin
               user_hits++;
               user_pos = out_beat;
            end
            if (b.l) begin
               $display("pkt %0d out: %0d beats %0d bytes tuser=%0d", out_pkts, out_beat, out_bytes, AXIS_OUT_TUSER);
               out_pkts++;
               last_user = AXIS_OUT_TUSER;
               user_hist = {user_hist[6:0], AXIS_OUT_TUSER};
               out_beat  = 0;
               out_bytes = 0;
            end
         end
         if (AXIS_IN_TVALID && AXIS_IN_TREADY) begin
            beat_t b;
            bit runt, giant, bad;
            m_len += $countones(AXIS_IN_TKEEP);
            m_err |= AXIS_IN_TUSER;
            runt  = (m_len < MIN_B);
            giant = (m_len > MAX_B);
            bad   = runt || giant || m_err;
            b.d = AXIS_IN_TDATA; b.k = AXIS_IN_TKEEP; b.l = AXIS_IN_TLAST;
            b.u = AXIS_IN_TLAST && bad;
            exp_q.push_back(b);
            if (AXIS_IN_TLAST) begin
               if (!bad)  m_cnt[0]++;
               if (runt)  m_cnt[1]++;
               if (giant) m_cnt[2]++;
               if (m_err) m_cnt[3]++;
               m_strb = bad;
               m_len  = 0;
               m_err  = 0;
            end
         end
         if (clear_counters) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
         m_ready_en = 1;
      end
   end

   always @(posedge clk) begin
      #1;
      AXIS_OUT_TREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // ---------------- stimulus ----------------
   task automatic set_beat(input int nb, input bit last, input bit user);
      for (int w = 0; w < DW / 32; w++) AXIS_IN_TDATA[w*32 +: 32] = $urandom;
      AXIS_IN_TKEEP = '0;
      for (int i = 0; i < nb; i++) AXIS_IN_TKEEP[i] = 1'b1;
      AXIS_IN_TLAST  = last;
      AXIS_IN_TUSER  = user;
      AXIS_IN_TVALID = 1'b1;
   endtask

   task automatic send_beat(input int nb, input bit last, input bit user);
      bit took;
      int guard;
      set_beat(nb, last, user);
      guard = 0;
      forever begin
         @(negedge clk);
         took = AXIS_IN_TREADY && !reset;
         @(posedge clk);
         #1;
         if (took) break;
         guard++;
         if (guard > 2000) begin
            n_total++;
            $display("FAIL accept_timeout: beat not accepted in 2000 cycles");
            break;
         end
      end
      AXIS_IN_TVALID = 1'b0;
   endtask

   task automatic send_pkt(input int nbytes, input int err_beat);
      int beats, nb;
      beats = (nbytes + 63) / 64;
      if (beats == 0) beats = 1;
      for (int b = 1; b <= beats; b++) begin
         nb = nbytes - 64 * (b - 1);
         if (nb > 64) nb = 64;
         send_beat(nb, b == beats, b == err_beat);
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() == 0 && !AXIS_OUT_TVALID) break;
         guard++;
         if (guard > 2000) begin
            n_total++;
            $display("FAIL drain_timeout: output not empty after 2000 cycles");
            break;
         end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      reset = 1'b1;
      AXIS_IN_TDATA = '0; AXIS_IN_TKEEP = '0; AXIS_IN_TUSER = 1'b0;
      AXIS_IN_TLAST = 1'b0; AXIS_IN_TVALID = 1'b0; clear_counters = 1'b0;
      rand_ready = 0;
      clear_stats();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // 60-byte single-beat runt
      send_pkt(60, 0);
      drain();
      chk("runt60_runt_count", 64'(runt_count), 64'(1));
      chk("runt60_good_count", 64'(good_count), 64'(0));
      chk("runt60_tuser", 64'(last_user), 64'(1));
      chk("runt60_strb_pulses", 64'(strb_hits), 64'(1));

      // boundary lengths 64, 9600, 9601
      clear_counters = 1'b1;
      @(posedge clk); #1 clear_counters = 1'b0;
      clear_stats();
      send_pkt(64, 0);
      send_pkt(9600, 0);
      send_pkt(9601, 0);
      drain();
      chk("bound_tuser_seq", 64'(user_hist[2:0]), 64'(3'b001));
      chk("bound_good_count", 64'(good_count), 64'(2));
      chk("bound_giant_count", 64'(giant_count), 64'(1));
      chk("bound_runt_count", 64'(runt_count), 64'(0));

      // 200-beat 12800-byte packet, upstream error on beat 3
      clear_counters = 1'b1;
      @(posedge clk); #1 clear_counters = 1'b0;
      clear_stats();
      send_pkt(12800, 3);
      drain();
      chk("long_tuser_hits", 64'(user_hits), 64'(1));
      chk("long_tuser_beat", 64'(user_pos), 64'(200));
      chk("long_giant_count", 64'(giant_count), 64'(1));
      chk("long_uerr_count", 64'(upstream_err_count), 64'(1));
      chk("long_good_count", 64'(good_count), 64'(0));

      // full throughput: 20 back-to-back 2-beat packets in 40 cycles
      t0 = cyc;
      for (int p = 0; p < 20; p++) send_pkt(128, 0);
      chk("throughput_cycles", 64'(cyc - t0), 64'(40));
      drain();

      // 1000 random packets with 50% output ready
      clear_stats();
      rand_ready = 1;
      for (int p = 0; p < 1000; p++) begin
         send_pkt(int'($urandom_range(1, 200)), ($urandom_range(0, 15) == 0) ? 1 : 0);
      end
      drain();
      rand_ready = 0;
      chk("random_pkt_count", 64'(out_pkts), 64'(1000));

      // reset on beat 2 of a 3-beat packet, then a fresh 128-byte packet
      send_beat(64, 0, 0);
      set_beat(64, 0, 0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      AXIS_IN_TVALID = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      #1;
      chk("postrst_good_count", 64'(good_count), 64'(0));
      chk("postrst_ready_low", 64'(AXIS_IN_TREADY), 64'(0));
      clear_stats();
      send_pkt(128, 0);
      drain();
      chk("postrst_pkt_tuser", 64'(last_user), 64'(0));
      chk("postrst_good_one", 64'(good_count), 64'(1));
      chk("postrst_out_pkts", 64'(out_pkts), 64'(1));

      // clear_counters coincident with a TLAST acceptance
      send_pkt(64, 0);
      drain();
      chk("preclr_good_count", 64'(good_count), 64'(2));
      clear_counters = 1'b1;
      send_beat(60, 1, 0);
      clear_counters = 1'b0;
      chk("clr_good_count", 64'(good_count), 64'(0));
      chk("clr_runt_count", 64'(runt_count), 64'(0));
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/packet_length_checker.md
PACKET_LENGTH_CHECKER -- requirements
Module: packet_length_checker

Interface
REQ-001 The block SHALL take parameter DW, default 512: TDATA width in bits, a multiple of 8.
REQ-002 The block SHALL take parameter MIN_BYTES, default 64: minimum legal packet length in bytes.
REQ-003 The block SHALL take parameter MAX_BYTES, default 9600: maximum legal packet length in bytes, below 65535.
REQ-004 Ports SHALL be: clk  in  1  sole clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 AXIS_IN_TDATA  in  DW; AXIS_IN_TKEEP  in  DW/8; AXIS_IN_TUSER  in  1  upstream error; AXIS_IN_TLAST  in  1; AXIS_IN_TVALID  in  1; AXIS_IN_TREADY  out  1.
REQ-007 AXIS_OUT_TDATA  out  DW; AXIS_OUT_TKEEP  out  DW/8; AXIS_OUT_TUSER  out  1  bad-packet mark; AXIS_OUT_TLAST  out  1; AXIS_OUT_TVALID  out  1; AXIS_OUT_TREADY  in  1.
REQ-008 clear_counters  in  1  synchronous clear of all statistics counters.
REQ-009 good_count, runt_count, giant_count, upstream_err_count  out  32 each  packet statistics.
REQ-010 bad_packet_strb  out  1  one-cycle pulse per bad packet, issued at input acceptance of its last beat.

Function
REQ-011 Beat acceptance SHALL be TVALID&TREADY on each side; TDATA, TKEEP and TLAST SHALL pass unmodified and in order.
REQ-012 The datapath SHALL be a 2-entry skid buffer: latency 1 cycle from input acceptance to AXIS_OUT_TVALID; sustained throughput 1 beat/cycle.
REQ-013 AXIS_IN_TREADY SHALL be high when fewer than 2 entries are occupied; the buffer SHALL never drop or duplicate a beat.
REQ-014 The output SHALL hold TDATA, TKEEP, TUSER and TLAST stable while TVALID=1 and TREADY=0.
REQ-015 The per-beat byte count SHALL be the popcount of TKEEP; TKEEP is contiguous from bit 0, and a beat with TKEEP=0 SHALL count 0 bytes.
REQ-016 A 16-bit accumulator SHALL sum byte counts of accepted beats, saturate at 65535, and clear after the TLAST beat is accepted.
REQ-017 Packet length SHALL be accumulator plus the byte count of the TLAST beat, evaluated at input acceptance of that beat.
REQ-018 runt = length < MIN_BYTES; giant = length > MAX_BYTES; upstream error = TUSER sampled high on any beat of the packet (sticky to TLAST).
REQ-019 AXIS_OUT_TUSER SHALL be runt|giant|upstream error on the TLAST beat and 0 on all other beats.
REQ-020 Counters SHALL increment once per packet at TLAST acceptance: good_count if not bad; runt_count if runt; giant_count if giant; upstream_err_count if upstream error (several may increment for one packet).
REQ-021 Counters SHALL saturate at 0xFFFFFFFF.
REQ-022 clear_counters SHALL take priority over a simultaneous increment; all counters read 0 next cycle.
REQ-023 A single-beat packet SHALL be checked like any other packet.
REQ-024 Back-to-back packets SHALL incur no idle cycles.

Reset
REQ-025 During reset: AXIS_IN_TREADY=0, AXIS_OUT_TVALID=0, AXIS_OUT_TUSER=0, AXIS_OUT_TLAST=0, bad_packet_strb=0, all counters=0, accumulator and sticky error=0, skid buffer empty.
REQ-026 After reset deassertion, AXIS_IN_TREADY SHALL rise on the first clock edge.
REQ-027 Reset mid-packet SHALL discard buffered beats; the first beat accepted after reset SHALL begin a new packet.

Structure
REQ-028 A shared package SHALL hold the accumulator width (16), the counter width (32) and the popcount function.
REQ-029 The skid buffer SHALL be a sub-module, axis_skid_buffer, with a parameterised payload width.

Verification
REQ-030 60-byte packet (DW=512, one beat, TKEEP=60 ones) -> TUSER=1 on TLAST, runt_count=1, bad_packet_strb pulses once.
REQ-031 Packet of 64 bytes, then 9600, then 9601 -> TUSER 0,0,1; good_count=2, giant_count=1.
REQ-032 200-beat 12800-byte packet with AXIS_IN_TUSER=1 on beat 3 only -> TUSER=1 on beat 200 only; giant_count=1, upstream_err_count=1.
REQ-033 Random AXIS_OUT_TREADY (50%) over 1000 back-to-back packets -> output identical to input, no loss; with TREADY held 1, 1 beat/cycle.
REQ-034 Reset asserted on beat 2 of a 3-beat packet, then a fresh 128-byte packet -> TVALID=0 during reset, counters 0, new packet TUSER=0, good_count=1.
REQ-035 clear_counters coincident with a TLAST acceptance -> all counters read 0 next cycle.
